// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Parity modes, receiver FSM states and the parity-bit function.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;
    localparam int MAX_DATA_W  = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } rx_state_t;

    // Zero-extending the word leaves its XOR unchanged, so one width fits all.
    function automatic logic parity_bit(
        input logic [MAX_DATA_W-1:0] d,
        input int                    mode
    );
        parity_bit = (mode == PARITY_ODD) ? ~(^d) : ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with head-of-queue read port.
// Head data reads as zero while empty; push and pop may share a cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, oversampling FSM with
// majority vote, break detection and a flagged receive FIFO.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int OVS         = 16,
    parameter int OVS_DIV     = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          RST,
    input  logic                          enable,
    input  logic                          in,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             out,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          RX_done,
    output logic                          RX_busy,
    output logic                          overrun,
    output logic                          break_det,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int TW = $clog2(OVS);
    localparam int DW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;

    localparam logic [TW-1:0] T_S0  = TW'(OVS/2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(OVS/2);
    localparam logic [TW-1:0] T_S2  = TW'(OVS/2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVS - 1);
    localparam logic [DW-1:0] D_END = DW'(OVS_DIV - 1);
    localparam logic [3:0]    LAST_D = 4'(DATA_W - 1);
    localparam logic [3:0]    LAST_S = 4'(STOP_BITS - 1);

    logic              sync1_q;
    logic              sync2_q;
    logic              prev_q;
    rx_state_t         state_q;
    logic [DW-1:0]     div_q;
    logic [TW-1:0]     tcnt_q;
    logic [3:0]        bcnt_q;
    logic [DATA_W-1:0] shreg_q;
    logic [1:0]        smp_q;
    logic              perr_q;
    logic              ferr_q;
    logic              zero_q;
    logic              ovr_q;
    logic              brk_q;

    logic                  tick;
    logic                  maj;
    logic                  decide;
    logic                  bit_end;
    logic                  start_edge;
    logic                  ferr_now;
    logic                  is_break;
    logic                  push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [MAX_DATA_W-1:0] data_ext;
    logic [DATA_W+1:0]     wdata;
    logic [DATA_W+1:0]     rdata;

    always_comb begin
        tick       = (state_q != IDLE) && (div_q == D_END);
        maj        = (smp_q[1] & smp_q[0]) | (smp_q[1] & sync2_q)
                   | (smp_q[0] & sync2_q);
        decide     = tick && (tcnt_q == T_S2);
        bit_end    = tick && (tcnt_q == T_END);
        start_edge = enable && prev_q && !sync2_q;
        data_ext   = '0;
        data_ext[DATA_W-1:0] = shreg_q;
        ferr_now   = ferr_q | ~maj;
        is_break   = zero_q && !maj && (bcnt_q == '0);
        push       = enable && (state_q == STOP) && decide
                   && !is_break && (bcnt_q == LAST_S);
        wdata      = {shreg_q, perr_q, ferr_now};
    end

    // prev_q gives a falling-edge start, so a line already low never arms.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            div_q   <= '0;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            smp_q   <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovr_q   <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            ovr_q <= push && fifo_full && !rd_en;
            brk_q <= 1'b0;
            if (state_q == IDLE || div_q == D_END) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + 1'b1;
            end
            if (tick) begin
                tcnt_q <= (tcnt_q == T_END) ? '0 : tcnt_q + 1'b1;
                if (tcnt_q == T_S0) smp_q[1] <= sync2_q;
                if (tcnt_q == T_S1) smp_q[0] <= sync2_q;
            end
            if (!enable) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start_edge) begin
                            state_q <= START;
                            div_q   <= '0;
                            tcnt_q  <= '0;
                            bcnt_q  <= '0;
                            zero_q  <= 1'b1;
                            perr_q  <= 1'b0;
                            ferr_q  <= 1'b0;
                        end
                    end
                    START: begin
                        if (decide && maj) state_q <= IDLE;
                        else if (bit_end)  state_q <= DATA;
                    end
                    DATA: begin
                        if (decide) begin
                            shreg_q <= {maj, shreg_q[DATA_W-1:1]};
                            if (maj) zero_q <= 1'b0;
                        end
                        if (bit_end) begin
                            if (bcnt_q == LAST_D) begin
                                bcnt_q  <= '0;
                                state_q <= (PARITY_MODE != PARITY_NONE)
                                         ? PARITY : STOP;
                            end else begin
                                bcnt_q <= bcnt_q + 4'd1;
                            end
                        end
                    end
                    PARITY: begin
                        if (decide) begin
                            perr_q <= maj != parity_bit(data_ext, PARITY_MODE);
                            if (maj) zero_q <= 1'b0;
                        end
                        if (bit_end) state_q <= STOP;
                    end
                    STOP: begin
                        if (decide) begin
                            ferr_q <= ferr_now;
                            if (is_break) begin
                                brk_q   <= 1'b1;
                                state_q <= BREAK_WAIT;
                            end else if (bcnt_q == LAST_S) begin
                                state_q <= IDLE;
                            end
                        end
                        if (bit_end) bcnt_q <= bcnt_q + 4'd1;
                    end
                    BREAK_WAIT: begin
                        if (sync2_q) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (RST),
        .wr_en (push),
        .rd_en (rd_en),
        .wdata (wdata),
        .rdata (rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {out, parity_err, frame_err} = rdata;
    assign RX_done   = !fifo_empty;
    assign RX_busy   = (state_q != IDLE);
    assign overrun   = ovr_q;
    assign break_det = brk_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: default build plus a narrow/slow build,
// checked each cycle against a frame-level queue model.
module tb_uart_rx_param;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } ent_t;

    localparam int DWV  [2] = '{8, 7};
    localparam int PMV  [2] = '{1, 2};
    localparam int SBV  [2] = '{1, 2};
    localparam int OVSV [2] = '{16, 8};
    localparam int DIVV [2] = '{1, 3};

    logic       clk = 1'b0;
    logic       RST;
    logic       in0, in1, en0, en1, rd0, rd1;
    logic [7:0] out0;
    logic [6:0] out1;
    logic       pe0, pe1, fe0, fe1, done0, done1;
    logic       busy0, busy1, ovr0, ovr1, brk0, brk1;
    logic [2:0] cnt0, cnt1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int first_done0 = -1;
    int brkcnt0 = 0;
    int ovrcnt0 = 0;

    ent_t mq [2][4];
    int   mh [2];
    int   mc [2];
    logic pv [2];
    int   pdue [2];
    ent_t pent [2];
    logic pbrk [2];
    logic eo [2];
    logic eb [2];

    always #5 clk = ~clk;

    uart_rx_param u_dut0 (
        .clk(clk), .RST(RST), .enable(en0), .in(in0), .rd_en(rd0),
        .out(out0), .parity_err(pe0), .frame_err(fe0),
        .RX_done(done0), .RX_busy(busy0), .overrun(ovr0),
        .break_det(brk0), .fifo_count(cnt0)
    );

    uart_rx_param #(
        .DATA_W(7), .PARITY_MODE(2), .STOP_BITS(2),
        .OVS(8), .OVS_DIV(3), .FIFO_DEPTH(4)
    ) u_dut1 (
        .clk(clk), .RST(RST), .enable(en1), .in(in1), .rd_en(rd1),
        .out(out1), .parity_err(pe1), .frame_err(fe1),
        .RX_done(done1), .RX_busy(busy1), .overrun(ovr1),
        .break_det(brk1), .fifo_count(cnt1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: a word lands in the queue one clk after its last stop mid-sample.
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            eo[i] = 1'b0;
            eb[i] = 1'b0;
            if (RST) begin
                mh[i] = 0;
                mc[i] = 0;
                pv[i] = 1'b0;
            end else begin
                if (((i == 0) ? rd0 : rd1) && mc[i] > 0) begin
                    mh[i] = (mh[i] + 1) % 4;
                    mc[i] = mc[i] - 1;
                end
                if (pv[i] && pdue[i] == cyc) begin
                    pv[i] = 1'b0;
                    if (pbrk[i]) eb[i] = 1'b1;
                    else if (mc[i] < 4) begin
                        mq[i][(mh[i] + mc[i]) % 4] = pent[i];
                        mc[i] = mc[i] + 1;
                    end else eo[i] = 1'b1;
                end
            end
        end
    end

    task automatic cmp(input int i, input logic [8:0] o,
                       input logic pe, input logic fe, input logic dn,
                       input logic ov, input logic bk, input logic [2:0] c);
        ent_t h;
        h = '0;
        if (mc[i] > 0) h = mq[i][mh[i]];
        chk($sformatf("u%0d.out", i), 32'(o), 32'(h.d));
        chk($sformatf("u%0d.parity_err", i), 32'(pe), 32'(h.pe));
        chk($sformatf("u%0d.frame_err", i), 32'(fe), 32'(h.fe));
        chk($sformatf("u%0d.RX_done", i), 32'(dn), 32'(mc[i] > 0));
        chk($sformatf("u%0d.fifo_count", i), 32'(c), 32'(mc[i]));
        chk($sformatf("u%0d.overrun", i), 32'(ov), 32'(eo[i]));
        chk($sformatf("u%0d.break_det", i), 32'(bk), 32'(eb[i]));
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            cmp(0, {1'b0, out0}, pe0, fe0, done0, ovr0, brk0, cnt0);
            cmp(1, {2'b0, out1}, pe1, fe1, done1, ovr1, brk1, cnt1);
            if (done0 && first_done0 < 0) first_done0 = cyc;
            if (brk0) brkcnt0++;
            if (ovr0) ovrcnt0++;
        end
    end

    task automatic expect_frame(input int i, input int n, input logic [8:0] d,
                                input logic par, input logic [1:0] st);
        logic [8:0] m;
        logic       pexp;
        logic       brk;
        int         pm;
        int         b;
        pm   = (PMV[i] != 0) ? 1 : 0;
        m    = d & ((9'h1 << DWV[i]) - 9'h1);
        pexp = (PMV[i] == 2) ? ~(^m) : ^m;
        brk  = (m == 0) && (pm == 0 || !par) && !st[0];
        b    = brk ? 1 + DWV[i] + pm : DWV[i] + pm + SBV[i];
        pent[i].d  = m;
        pent[i].pe = (pm == 1) && (par != pexp);
        pent[i].fe = !st[0] || (SBV[i] == 2 && !st[1]);
        pbrk[i] = brk;
        pdue[i] = n + 3 + (b * OVSV[i] + OVSV[i] / 2 + 2) * DIVV[i];
        pv[i]   = 1'b1;
    endtask

    task automatic drive_bit(input int i, input logic v, input int nclk);
        if (i == 0) in0 = v;
        else in1 = v;
        repeat (nclk) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int i, input logic [8:0] d,
                              input logic par, input logic [1:0] st);
        int bc;
        bc = OVSV[i] * DIVV[i];
        expect_frame(i, cyc, d, par, st);
        drive_bit(i, 1'b0, bc);
        for (int k = 0; k < DWV[i]; k++) drive_bit(i, d[k], bc);
        if (PMV[i] != 0) drive_bit(i, par, bc);
        for (int k = 0; k < SBV[i]; k++) drive_bit(i, st[k], bc);
        drive_bit(i, 1'b1, 2 * bc);
    endtask

    task automatic pop(input int i);
        if (i == 0) rd0 = 1'b1;
        else rd1 = 1'b1;
        @(posedge clk);
        #1;
        rd0 = 1'b0;
        rd1 = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [8:0] dv;
        RST = 1'b1;
        in0 = 1'b1; in1 = 1'b1;
        en0 = 1'b1; en1 = 1'b1;
        rd0 = 1'b0; rd1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out", 32'(out0), 32'h0);
        chk("rst.RX_done", 32'(done0), 32'h0);
        chk("rst.RX_busy", 32'(busy0), 32'h0);
        chk("rst.fifo_count", 32'(cnt0), 32'h0);
        RST = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        n = cyc;
        send_frame(0, 9'h0DF, 1'b1, 2'b11);
        chk("lat.done", 32'(first_done0), 32'(n + 173));
        send_frame(0, 9'h0DF, 1'b0, 2'b11);
        send_frame(0, 9'h0DF, 1'b1, 2'b10);
        chk("three.count", 32'(cnt0), 32'd3);
        chk("f1.out", 32'(out0), 32'hDF);
        chk("f1.pe", 32'(pe0), 32'd0);
        chk("f1.fe", 32'(fe0), 32'd0);
        pop(0);
        chk("f2.out", 32'(out0), 32'hDF);
        chk("f2.pe", 32'(pe0), 32'd1);
        chk("f2.fe", 32'(fe0), 32'd0);
        pop(0);
        chk("f3.pe", 32'(pe0), 32'd0);
        chk("f3.fe", 32'(fe0), 32'd1);
        pop(0);
        chk("drain.done", 32'(done0), 32'd0);

        drive_bit(0, 1'b0, 5);
        chk("glitch.busy", 32'(busy0), 32'd1);
        drive_bit(0, 1'b1, 20);
        chk("glitch.idle", 32'(busy0), 32'd0);
        chk("glitch.done", 32'(done0), 32'd0);
        chk("glitch.count", 32'(cnt0), 32'd0);

        expect_frame(0, cyc, 9'h0, 1'b0, 2'b00);
        drive_bit(0, 1'b0, 12 * 16);
        chk("brk.busy", 32'(busy0), 32'd1);
        drive_bit(0, 1'b1, 10);
        chk("brk.idle", 32'(busy0), 32'd0);
        chk("brk.pulses", 32'(brkcnt0), 32'd1);
        chk("brk.count", 32'(cnt0), 32'd0);
        drive_bit(0, 1'b1, 20);

        for (int v = 1; v <= 5; v++) begin
            dv = 9'(v);
            send_frame(0, dv, ^dv, 2'b11);
        end
        chk("ovr.count", 32'(cnt0), 32'd4);
        chk("ovr.pulses", 32'(ovrcnt0), 32'd1);
        for (int v = 1; v <= 4; v++) begin
            chk($sformatf("pop%0d.out", v), 32'(out0), 32'(v));
            pop(0);
        end
        chk("ovr.done", 32'(done0), 32'd0);

        send_frame(1, 9'h055, 1'b1, 2'b11);
        chk("sw.out", 32'(out1), 32'h55);
        chk("sw.pe", 32'(pe1), 32'd0);
        chk("sw.fe", 32'(fe1), 32'd0);
        drive_bit(1, 1'b0, 24);
        drive_bit(1, 1'b0, 24);
        drive_bit(1, 1'b1, 24);
        drive_bit(1, 1'b0, 24);
        chk("sw.busy", 32'(busy1), 32'd1);
        en1 = 1'b0;
        @(posedge clk);
        #1;
        chk("sw.drop", 32'(busy1), 32'd0);
        drive_bit(1, 1'b1, 50);
        en1 = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("sw.count", 32'(cnt1), 32'd1);
        chk("sw.keep", 32'(out1), 32'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8-bit receiver.
- Configurable data width, parity mode, stop-bit count and oversampling ratio.
- 3-sample majority vote at mid-bit, with false-start rejection and break detection.
- Small receive FIFO carrying per-word error flags.
- Sits behind the APB UART register block; the bus side pops words with rd_en.

Parameters:
DATA_W, 8, data bits per frame (5..9), LSB first
PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits checked (1 or 2)
OVS, 16, oversample ticks per bit (even, >= 8)
OVS_DIV, 1, clk cycles per oversample tick (1 = tick every clk)
FIFO_DEPTH, 4, receive FIFO entries (power of 2, >= 2)

Ports:
clk  in  1  system clock
RST  in  1  asynchronous active-high reset
enable  in  1  receiver enable; low forces the FSM to IDLE
in  in  1  serial line, idle high, asynchronous to clk
rd_en  in  1  pop head FIFO entry (ignored when empty)
out  out  DATA_W  head FIFO data word
parity_err  out  1  parity-error flag of the head entry
frame_err  out  1  framing-error flag of the head entry
RX_done  out  1  FIFO non-empty (head entry valid)
RX_busy  out  1  FSM not in IDLE
overrun  out  1  1-cycle pulse: completed word dropped because FIFO full
break_det  out  1  1-cycle pulse on break detection
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held

Behaviour:
- Reset values: out=0, flags 0, RX_done=0, RX_busy=0, overrun=0, break_det=0, fifo_count=0; FIFO pointers 0.
- Synchroniser and tick generator:
  - in passes a 2-FF synchroniser reset to 1; all decisions use the synchronised value.
  - Tick divider counts 0..OVS_DIV-1. It is held at 0 in IDLE and restarts on start-edge detection.
- Sampling:
  - A per-bit tick counter runs 0..OVS-1.
  - Each bit is sampled at ticks OVS/2-1, OVS/2 and OVS/2+1; the bit value is the 2-of-3 majority.
  - The bit decision is taken on the cycle of the last sample.
- FSM states and transitions:
  - IDLE: synchronised line = 0 with enable = 1 -> START, counters cleared.
  - START: majority 1 -> IDLE (false start, nothing pushed). Majority 0 -> DATA at bit end.
  - DATA: shift in DATA_W bits LSB first. Then -> PARITY if PARITY_MODE != 0, else -> STOP.
  - PARITY: computed = XOR(data) for even, ~XOR(data) for odd; perr = (sampled != computed). -> STOP.
  - STOP: check STOP_BITS bits; any 0 sets ferr. After the last stop-bit decision: push, then -> IDLE (no wait for bit end).
  - BREAK_WAIT: stay until the synchronised line = 1, then -> IDLE.
- Break:
  - Condition: all data bits 0, parity bit 0 (if present) and first stop bit 0.
  - Action: break_det pulses, nothing is pushed, FSM -> BREAK_WAIT.
- Push and latency:
  - Push writes {data, perr, ferr}.
  - RX_done rises the cycle after the push decision, i.e. 1 clk after the last stop-bit mid-sample.
- FIFO:
  - out, parity_err and frame_err always show the head entry; they are 0 when empty.
  - rd_en with RX_done=1 pops; the next entry appears the following cycle.
  - Push while full with no pop: word dropped, overrun pulses, contents unchanged.
  - Push and pop in the same cycle: both occur, count unchanged, no overrun (including when full).
  - Pointers wrap modulo FIFO_DEPTH.
- enable low mid-frame: FSM -> IDLE next cycle, partial word discarded, FIFO untouched. Re-arms only after enable=1 and a new falling edge.
- RST mid-frame: everything returns to reset values immediately (asynchronous).

Decomposition:
- Shared package uart_pkg holds:
  - PARITY_NONE/EVEN/ODD constants;
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT};
  - a helper function for the parity bit.
- One sub-module: uart_rx_fifo, a parametrised synchronous FIFO (width DATA_W+2, depth FIFO_DEPTH) with count, full and empty outputs.
- Synchroniser, tick divider and FSM stay in the top module.

Test Plan:
- Default params: send start, data 0xDF (bits 1,1,1,1,1,0,1,1), parity 1, stop 1, each bit 16 clk -> out=0xDF, parity_err=0, frame_err=0, RX_done=1 one clk after stop mid-sample.
- Same frame with parity bit 0 -> out=0xDF, parity_err=1. Repeat with stop bit 0 -> frame_err=1, word still pushed.
- 5-clk low glitch on in while IDLE -> returns to IDLE, RX_busy drops, RX_done stays 0, fifo_count=0.
- Line held low for 12 bit times -> break_det single pulse, no push, RX_busy stays 1 until line high, then IDLE.
- FIFO_DEPTH=4: send 5 frames (0x01..0x05) with no reads -> fifo_count=4, overrun pulses on frame 5. Then pop 4 times -> out reads 0x01..0x04 in order, RX_done=0 afterwards.
- Parameter sweep DATA_W=7, PARITY_MODE=2, STOP_BITS=2, OVS=8, OVS_DIV=3: send 0x55, then drop enable mid-data on a second frame -> first word 0x55 with no errors; second frame discarded, fifo_count=1.
